// File: rtl/sqr_build_if.sv
// rtl/sqr_build_if.sv - start/operand/result bundle for the shift-add squarer
interface sqr_build_if #(
  parameter int WIDTH = 16
);
  logic               init;
  logic [WIDTH-1:0]   op_A;
  logic [WIDTH-1:0]   op_B;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (output init, output op_A, output op_B, input  done, input  result);
  modport slave  (input  init, input  op_A, input  op_B, output done, output result);
endinterface

// File: rtl/sqr_build.sv
// rtl/sqr_build.sv - rebuilds a radicand as op_A*op_A (+ op_B when SQR_BUILD_REM_EN
// is defined) with a fixed-latency shift-add multiplier FSM.
module sqr_build #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  sqr_build_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    START     = 2'd0,
    ADD_SHIFT = 2'd1,
    CHECK_Z   = 2'd2,
    END1      = 2'd3
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]     r_q;
  logic [CW-1:0]        r_count;
  logic                 r_done;
  logic [2*WIDTH-1:0]   w_acc_init;

`ifdef SQR_BUILD_REM_EN
  assign w_acc_init = {{WIDTH{1'b0}}, bus.op_B};
`else
  assign w_acc_init = '0;
`endif

  assign bus.done   = r_done;
  assign bus.result = r_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= START;
      r_m      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        START: begin
          r_done   <= 1'b0;
          r_result <= '0;
          if (bus.init) begin
            r_m     <= {{WIDTH{1'b0}}, bus.op_A};
            r_q     <= bus.op_A;
            r_acc   <= w_acc_init;
            r_count <= CW'(WIDTH);
            r_state <= ADD_SHIFT;
          end
        end
        ADD_SHIFT: begin
          if (r_q[0]) r_acc <= r_acc + r_m;
          r_m     <= r_m << 1;
          r_q     <= r_q >> 1;
          r_count <= r_count - 1'b1;
          r_state <= CHECK_Z;
        end
        CHECK_Z: begin
          r_state <= (r_count == '0) ? END1 : ADD_SHIFT;
        end
        END1: begin
          // First END1 edge always publishes, so a one-cycle init pulse still sees done.
          if (!r_done) begin
            r_done   <= 1'b1;
            r_result <= r_acc;
          end else if (!bus.init) begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_state  <= START;
          end
        end
        default: r_state <= START;
      endcase
    end
  end
endmodule

// File: tb/tb_sqr_build.sv
// tb/tb_sqr_build.sv - directed scoreboard bench for sqr_build
module tb_sqr_build;
  localparam int WIDTH = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [2*WIDTH-1:0] sb_q[$];
  logic [2*WIDTH-1:0] held;

  sqr_build_if #(.WIDTH(WIDTH)) bus ();

  sqr_build #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] wa;
    logic [2*WIDTH-1:0] r;
    wa = {{WIDTH{1'b0}}, a};
    r  = wa * wa;
`ifdef SQR_BUILD_REM_EN
    r  = r + {{WIDTH{1'b0}}, b};
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [2*WIDTH-1:0] obs, input logic [2*WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one request at the falling edge; the next rising edge is edge k.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic hold);
    @(negedge clk);
    bus.op_A = a;
    bus.op_B = b;
    bus.init = 1'b1;
    sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (!hold) bus.init = 1'b0;
  endtask

  // Waits edges k+1..k+33, checking done is late by none and early by none.
  task automatic expect_done(input string tag);
    logic [2*WIDTH-1:0] exp;
    for (int i = 1; i <= 2*WIDTH+1; i++) begin
      @(posedge clk);
      #1;
      if (i == 2*WIDTH) check({tag, "_not_early"}, {31'd0, bus.done}, 32'd0);
    end
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_result"}, bus.result, exp);
    end
  endtask

  task automatic expect_clear(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_clr"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_res_clr"}, bus.result, 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    bus.init = 1'b0;
    bus.op_A = '0;
    bus.op_B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_done", {31'd0, bus.done}, 32'd0);

    start_op(16'd12, 16'd5, 1'b0);
    expect_done("a12");
    expect_clear("a12");

    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    expect_done("aFFFF");
    expect_clear("aFFFF");

    start_op(16'd0, 16'd0, 1'b0);
    expect_done("a0");
    expect_clear("a0");

    // Reset mid-computation must clear outputs without waiting for an edge.
    start_op(16'd200, 16'd9, 1'b0);
    void'(sb_q.pop_back());
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    start_op(16'd3, 16'd7, 1'b0);
    expect_done("a3");
    expect_clear("a3");

    start_op(16'd7, 16'd2, 1'b1);
    expect_done("hold");
    held = model(16'd7, 16'd2);
    repeat (4) @(posedge clk);
    #1;
    check("hold_done", {31'd0, bus.done}, 32'd1);
    check("hold_result", bus.result, held);
    bus.init = 1'b0;
    expect_clear("hold");
    start_op(16'd100, 16'd50, 1'b0);
    expect_done("repulse");
    expect_clear("repulse");

    start_op(16'd9, 16'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.op_A = 16'hAAAA;
    bus.op_B = 16'h5555;
    bus.init = 1'b1;
    @(posedge clk);
    #1;
    bus.init = 1'b0;
    for (int i = 5; i <= 2*WIDTH+1; i++) @(posedge clk);
    #1;
    check("captured_done", {31'd0, bus.done}, 32'd1);
    check("captured_result", bus.result, sb_q.pop_front());
    expect_clear("captured");

    for (int n = 0; n < 3; n++) begin
      start_op(16'($urandom), 16'($urandom), 1'b0);
      expect_done("rand");
      expect_clear("rand");
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
